// File: rtl/gpio_mulpop_pkg.sv
// Shared constants for the GPIO multiply/popcount accelerator: register
// offsets, status bit positions and the core FSM encoding.
package gpio_mulpop_pkg;

  localparam logic [15:0] OFF_A1   = 16'h0000;
  localparam logic [15:0] OFF_A2   = 16'h0008;
  localparam logic [15:0] OFF_W    = 16'h0010;
  localparam logic [15:0] OFF_L    = 16'h0018;
  localparam logic [15:0] OFF_CTRL = 16'h0020;

  localparam int STAT_VALID_BIT = 0;
  localparam int STAT_READY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_ERROR_BIT = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_POP,
    S_DONE
  } state_t;

endpackage

// File: rtl/mulpop_core.sv
// Sequential shift-add multiplier followed by a popcount of the truncated
// product. Operands are shadowed at start so the host may rewrite them.
module mulpop_core
  import gpio_mulpop_pkg::*;
#(
  parameter int OP_W  = 24,
  parameter int RES_W = 32,
  parameter int L_W   = 6
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start,
  input  logic [OP_W-1:0]  a1,
  input  logic [OP_W-1:0]  a2,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] w,
  output logic [L_W-1:0]   l,
  output logic             valid
);

  localparam int BC_W = $clog2(OP_W + 1);

  state_t              state;
  logic [2*OP_W-1:0]   mcand;
  logic [OP_W-1:0]     mplier;
  logic [2*OP_W-1:0]   acc;
  logic [BC_W-1:0]     bit_cnt;

  function automatic logic [L_W-1:0] popcount(input logic [RES_W-1:0] v);
    logic [L_W-1:0] n;
    n = '0;
    for (int i = 0; i < RES_W; i++) n = n + L_W'(v[i]);
    return n;
  endfunction

  // done is high for the single DONE cycle so the counter and busy drop together
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= S_IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      w       <= '0;
      l       <= '0;
      valid   <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand   <= {{OP_W{1'b0}}, a1};
            mplier  <= a2;
            acc     <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= S_MULT;
          end
        end
        S_MULT: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          bit_cnt <= bit_cnt + BC_W'(1);
          if (bit_cnt == BC_W'(OP_W - 1)) state <= S_POP;
        end
        S_POP: begin
          w     <= acc[RES_W-1:0];
          valid <= ((acc >> RES_W) == '0);
          l     <= popcount(acc[RES_W-1:0]);
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/gpio_mulpop.sv
// Bus front end for the multiply/popcount accelerator: strobe edge detection,
// register window decode, status/error, GPIO capture and completion counter.
module gpio_mulpop
  import gpio_mulpop_pkg::*;
#(
  parameter int          OP_W      = 24,
  parameter int          RES_W     = 32,
  parameter logic [15:0] BASE_ADDR = 16'h0380,
  parameter int          CNT_W     = 16
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_in_s_insp
);

  localparam int L_W = $clog2(RES_W + 1);

  logic              swr_p1, swr_p2, srd_p1, srd_p2, lat_p1, lat_p2;
  logic [15:0]       addr_p1;
  logic [31:0]       wdata_p1, gpio_p1;
  logic              wr_fire, rd_fire, lat_fire, start_req;
  logic [OP_W-1:0]   a1_q, a2_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              core_busy, core_done, core_valid;
  logic [RES_W-1:0]  core_w;
  logic [L_W-1:0]    core_l;
  logic [31:0]       status, rdata;

  function automatic logic hit(input logic [15:0] a, input logic [15:0] off);
    return a == 16'(BASE_ADDR + off);
  endfunction

  // Stage p1: strobes and their bus qualifiers sampled together; p2 is the prior sample
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      swr_p1   <= 1'b0;
      swr_p2   <= 1'b0;
      srd_p1   <= 1'b0;
      srd_p2   <= 1'b0;
      lat_p1   <= 1'b0;
      lat_p2   <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
      gpio_p1  <= '0;
    end else begin
      swr_p1   <= swr;
      swr_p2   <= swr_p1;
      srd_p1   <= srd;
      srd_p2   <= srd_p1;
      lat_p1   <= gpio_latch;
      lat_p2   <= lat_p1;
      addr_p1  <= saddress;
      wdata_p1 <= sdata_in;
      gpio_p1  <= gpio_in;
    end
  end

  assign wr_fire   = swr_p1 & ~swr_p2;
  assign rd_fire   = srd_p1 & ~srd_p2;
  assign lat_fire  = lat_p1 & ~lat_p2;
  assign start_req = wr_fire & hit(addr_p1, OFF_CTRL);

  mulpop_core #(
    .OP_W  (OP_W),
    .RES_W (RES_W),
    .L_W   (L_W)
  ) u_core (
    .clk     (clk),
    .n_reset (n_reset),
    .start   (start_req),
    .a1      (a1_q),
    .a2      (a2_q),
    .busy    (core_busy),
    .done    (core_done),
    .w       (core_w),
    .l       (core_l),
    .valid   (core_valid)
  );

  always_comb begin
    status                 = '0;
    status[STAT_VALID_BIT] = core_valid;
    status[STAT_READY_BIT] = ~core_busy;
    status[STAT_BUSY_BIT]  = core_busy;
    status[STAT_ERROR_BIT] = err_q;
  end

  always_comb begin
    rdata = '0;
    if (hit(addr_p1, OFF_A1))        rdata = 32'(a1_q);
    else if (hit(addr_p1, OFF_A2))   rdata = 32'(a2_q);
    else if (hit(addr_p1, OFF_W))    rdata = 32'(core_w);
    else if (hit(addr_p1, OFF_L))    rdata = 32'(core_l);
    else if (hit(addr_p1, OFF_CTRL)) rdata = status;
  end

  // Stage p2: register file, error, counter and read data updated on fired accesses
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a1_q           <= '0;
      a2_q           <= '0;
      err_q          <= 1'b0;
      cnt_q          <= '0;
      sdata_out      <= '0;
      gpio_in_s_insp <= '0;
    end else begin
      if (wr_fire && hit(addr_p1, OFF_A1)) a1_q <= wdata_p1[OP_W-1:0];
      if (wr_fire && hit(addr_p1, OFF_A2)) a2_q <= wdata_p1[OP_W-1:0];
      // a start while busy wins over a same-cycle status-read clear
      if (start_req && core_busy)                  err_q <= 1'b1;
      else if (rd_fire && hit(addr_p1, OFF_CTRL))  err_q <= 1'b0;
      if (core_done) cnt_q <= cnt_q + CNT_W'(1);
      if (rd_fire)   sdata_out <= rdata;
      if (lat_fire)  gpio_in_s_insp <= gpio_p1;
    end
  end

  assign gpio_out = 32'(cnt_q);

endmodule
